// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode tags, flag bit positions and the buffered entry layout.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 8;
    localparam int unsigned ALU_OPW   = 3;

    // Opcode tags; the top opcode bit marks an arithmetic operation.
    localparam int unsigned OP_ARITH_BIT = ALU_OPW - 1;
    localparam logic [ALU_OPW-1:0] OP_AND = 3'b000;
    localparam logic [ALU_OPW-1:0] OP_OR  = 3'b001;
    localparam logic [ALU_OPW-1:0] OP_XOR = 3'b010;
    localparam logic [ALU_OPW-1:0] OP_NOT = 3'b011;
    localparam logic [ALU_OPW-1:0] OP_ADD = 3'b100;
    localparam logic [ALU_OPW-1:0] OP_SUB = 3'b101;

    // Flag vector {C, N, Z, P}.
    localparam int unsigned FLG_C = 3;
    localparam int unsigned FLG_N = 2;
    localparam int unsigned FLG_Z = 1;
    localparam int unsigned FLG_P = 0;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        logic [ALU_OPW-1:0]   op;
        logic [3:0]           flags;
    } alu_entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status flag derivation for one ALU result.
//   result_i : ALU result
//   carry_i  : adder carry-out (only meaningful for arithmetic ops)
//   op_i     : opcode tag, MSB set for arithmetic ops
//   flags_o  : {C, N, Z, P}
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OPW   = 3
) (
    input  logic [WIDTH-1:0] result_i,
    input  logic             carry_i,
    input  logic [OPW-1:0]   op_i,
    output logic [3:0]       flags_o
);

    // Only the arithmetic marker bit of the opcode affects the flags.
    logic unused_op;
    assign unused_op = ^op_i[OPW-2:0];

    always_comb begin
        flags_o        = 4'b0000;
        flags_o[FLG_C] = carry_i & op_i[OPW-1];
        flags_o[FLG_N] = result_i[WIDTH-1];
        flags_o[FLG_Z] = (result_i == '0);
        flags_o[FLG_P] = ^result_i;
    end

endmodule

// File: rtl/alu_result_stage.sv
// Two-entry skid buffer capturing ALU results with opcode tag and flags.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : upstream handshake
//   in_result/carry/op   : captured ALU result, carry-out and opcode tag
//   out_valid/out_ready  : downstream handshake
//   out_result/op/flags  : head entry payload
//   out_count            : wrapping count of pops since reset
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_carry,
    input  logic [OPW-1:0]   in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [OPW-1:0]   out_op,
    output logic [3:0]       out_flags,
    output logic [15:0]      out_count
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [OPW-1:0]   op;
        logic [3:0]       flags;
    } entry_t;

    // Occupancy states.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [15:0] count_q, count_d;
    entry_t      mem_q [2];
    logic [3:0]  flags_c;
    logic        push_c;
    logic        pop_c;

    alu_flag_gen #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_flag_gen (
        .result_i (in_result),
        .carry_i  (in_carry),
        .op_i     (in_op),
        .flags_o  (flags_c)
    );

    // Handshake derived from registered occupancy only.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign push_c    = in_valid && in_ready;
    assign pop_c     = out_valid && out_ready;

    // Next-state, pointer and counter logic.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q ^ push_c;
        rd_ptr_d = rd_ptr_q ^ pop_c;
        count_d  = pop_c ? count_q + 16'd1 : count_q;
        case (state_q)
            ST_EMPTY: if (push_c) state_d = ST_ONE;
            ST_ONE: begin
                if (push_c && !pop_c)      state_d = ST_FULL;
                else if (!push_c && pop_c) state_d = ST_EMPTY;
            end
            ST_FULL:  if (pop_c) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; only the write-pointer slot changes on a push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (push_c) begin
            mem_q[wr_ptr_q] <= '{result: in_result, op: in_op, flags: flags_c};
        end
    end

    assign out_result = mem_q[rd_ptr_q].result;
    assign out_op     = mem_q[rd_ptr_q].op;
    assign out_flags  = mem_q[rd_ptr_q].flags;
    assign out_count  = count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized and directed bench for alu_result_stage against a queue model.
module tb_alu_result_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_result = 8'h00;
    logic        in_carry = 1'b0;
    logic [2:0]  in_op = 3'b000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_result;
    logic [2:0]  out_op;
    logic [3:0]  out_flags;
    logic [15:0] out_count;

    int n_total = 0;
    int n_bad   = 0;

    alu_entry_t  mdl_q[$];
    logic [15:0] mdl_count = 16'd0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(8), .OPW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_carry   (in_carry),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_op     (out_op),
        .out_flags  (out_flags),
        .out_count  (out_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Flags straight from their definitions: popcount parity, sign, zero, masked carry.
    function automatic logic [3:0] ref_flags(input logic [7:0] r, input bit c, input logic [2:0] op);
        int ones = 0;
        for (int i = 0; i < 8; i++) if (r[i]) ones++;
        return {(c && op >= 3'd4), (r >= 8'd128), (r == 8'd0), (ones % 2 == 1)};
    endfunction

    // One clock cycle: drive, compare against model, advance model at the edge.
    task automatic cycle(input bit v, input bit r, input logic [7:0] res, input bit c,
                         input logic [2:0] op);
        bit do_push;
        bit do_pop;
        alu_entry_t e;
        in_valid  = v;
        out_ready = r;
        in_result = res;
        in_carry  = c;
        in_op     = op;
        #1;
        chk("out_valid", 32'(out_valid), 32'(mdl_q.size() != 0));
        chk("in_ready",  32'(in_ready),  32'(mdl_q.size() < 2));
        chk("out_count", 32'(out_count), 32'(mdl_count));
        if (mdl_q.size() != 0) begin
            chk("out_result", 32'(out_result), 32'(mdl_q[0].result));
            chk("out_op",     32'(out_op),     32'(mdl_q[0].op));
            chk("out_flags",  32'(out_flags),  32'(mdl_q[0].flags));
        end
        do_push = v && (mdl_q.size() < 2);
        do_pop  = r && (mdl_q.size() != 0);
        @(posedge clk);
        if (do_pop) begin
            void'(mdl_q.pop_front());
            mdl_count = mdl_count + 16'd1;
        end
        if (do_push) begin
            e.result = res;
            e.op     = op;
            e.flags  = ref_flags(res, c, op);
            mdl_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid",  32'(out_valid),  32'd0);
        chk("rst_in_ready",   32'(in_ready),   32'd1);
        chk("rst_out_count",  32'(out_count),  32'd0);
        chk("rst_out_result", 32'(out_result), 32'd0);
        chk("rst_out_flags",  32'(out_flags),  32'd0);
        chk("rst_out_op",     32'(out_op),     32'd0);
        mdl_q.delete();
        mdl_count = 16'd0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Logic op with carry set: C masked, Z set.
        cycle(1, 1, 8'h00, 1, OP_AND);
        chk("and_valid", 32'(out_valid),  32'd1);
        chk("and_res",   32'(out_result), 32'h00);
        chk("and_flags", 32'(out_flags),  32'b0010);
        cycle(0, 1, 8'h00, 0, OP_AND);
        chk("and_count", 32'(out_count), 32'd1);

        // Arithmetic op with carry.
        cycle(1, 1, 8'h80, 1, 3'b100);
        chk("add_flags", 32'(out_flags), 32'b1101);
        cycle(0, 1, 8'h00, 0, OP_AND);

        // Backpressure: third push held upstream until FULL is left.
        cycle(1, 0, 8'h11, 0, OP_OR);
        cycle(1, 0, 8'h22, 0, OP_XOR);
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        cycle(1, 0, 8'h33, 0, OP_ADD);
        cycle(1, 0, 8'h33, 0, OP_ADD);
        chk("bp_hold_res", 32'(out_result), 32'h11);
        cycle(1, 1, 8'h33, 0, OP_ADD);
        chk("bp_second", 32'(out_result), 32'h22);
        cycle(1, 1, 8'h33, 0, OP_ADD);
        chk("bp_third", 32'(out_result), 32'h33);
        cycle(0, 1, 8'h00, 0, OP_AND);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Streaming 100 back-to-back entries.
        do_reset();
        for (int i = 0; i < 100; i++)
            cycle(1, 1, 8'($urandom), 1'($urandom), 3'($urandom));
        cycle(0, 1, 8'h00, 0, OP_AND);
        chk("stream_count", 32'(out_count), 32'd100);

        // Reset while FULL, then a fresh entry.
        cycle(1, 0, 8'hA1, 0, OP_SUB);
        cycle(1, 0, 8'hA2, 0, OP_SUB);
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        do_reset();
        cycle(1, 1, 8'h5A, 0, OP_NOT);
        chk("post_rst_res", 32'(out_result), 32'h5A);
        cycle(0, 1, 8'h00, 0, OP_AND);

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            cycle(1'($urandom), ($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
                  3'($urandom));
        cycle(0, 1, 8'h00, 0, OP_AND);
        cycle(0, 1, 8'h00, 0, OP_AND);

        // Counter wrap after 65536 pops.
        do_reset();
        for (int i = 0; i < 65536; i++)
            cycle(1, 1, 8'($urandom), 1'($urandom), 3'($urandom));
        cycle(0, 1, 8'h00, 0, OP_AND);
        chk("wrap_count", 32'(out_count), 32'h0000);
        chk("wrap_empty", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
